// File: rtl/multibyte_alu_seq.sv
// multibyte_alu_seq: runs a 16-bit ADD/AND/OR through an external 8-bit ALU, low byte then high byte.
// Optional build macro SEQ_CARRY_IN_EN adds the in_cin port that feeds the low-byte ADD carry.
`ifndef ADD_FN
`define ADD_FN 2'b00
`endif
`ifndef AND_FN
`define AND_FN 2'b01
`endif
`ifndef OR_FN
`define OR_FN 2'b10
`endif

module multibyte_alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [1:0]  in_op,
`ifdef SEQ_CARRY_IN_EN
  input  logic        in_cin,
`endif
  output logic [7:0]  alu_in1,
  output logic [7:0]  alu_in2,
  output logic        alu_c_in,
  output logic [1:0]  alu_opcode,
  input  logic [7:0]  alu_out,
  input  logic [2:0]  alu_czn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [2:0]  out_czn,
  output logic        out_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic        cin_q, cin_d, carry_q, carry_d;
  logic [7:0]  res_lo_q, res_lo_d;
  logic [15:0] out_result_q, out_result_d;
  logic [2:0]  out_czn_q, out_czn_d;
  logic        out_err_q, out_err_d;
  logic        cin_in, in_op_legal, is_add;
  logic [15:0] full_result;
  logic        unused_alu_flags;

`ifdef SEQ_CARRY_IN_EN
  assign cin_in = in_cin;
`else
  assign cin_in = 1'b0;
`endif

  assign in_op_legal = (in_op == `ADD_FN) || (in_op == `AND_FN) || (in_op == `OR_FN);
  assign is_add      = (op_q == `ADD_FN);
  assign full_result = {alu_out, res_lo_q};
  // The ALU's Z and N only describe one byte; both are rebuilt over the full 16-bit result.
  assign unused_alu_flags = ^alu_czn[2:1];

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = out_result_q;
  assign out_czn    = out_czn_q;
  assign out_err    = out_err_q;

  always_comb begin
    // NOTE: every variable gets its hold/idle value first, so no branch of the case can infer a latch.
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    cin_d        = cin_q;
    carry_d      = carry_q;
    res_lo_d     = res_lo_q;
    out_result_d = out_result_q;
    out_czn_d    = out_czn_q;
    out_err_d    = out_err_q;
    alu_in1      = '0;
    alu_in2      = '0;
    alu_c_in     = 1'b0;
    alu_opcode   = '0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          op_d  = in_op;
          cin_d = cin_in;
          if (in_op_legal) begin
            state_d = LO;
          end else begin
            out_result_d = '0;
            out_czn_d    = '0;
            out_err_d    = 1'b1;
            state_d      = DONE;
          end
        end
      end
      LO: begin
        alu_in1    = a_q[7:0];
        alu_in2    = b_q[7:0];
        alu_opcode = op_q;
        alu_c_in   = is_add ? cin_q : 1'b0;
        res_lo_d   = alu_out;
        carry_d    = alu_czn[0];
        state_d    = HI;
      end
      HI: begin
        alu_in1      = a_q[15:8];
        alu_in2      = b_q[15:8];
        alu_opcode   = op_q;
        alu_c_in     = is_add ? carry_q : 1'b0;
        out_result_d = full_result;
        out_czn_d    = {full_result[15], (full_result == 16'h0000), is_add & alu_czn[0]};
        out_err_d    = 1'b0;
        state_d      = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      cin_q        <= 1'b0;
      carry_q      <= 1'b0;
      res_lo_q     <= '0;
      out_result_q <= '0;
      out_czn_q    <= '0;
      out_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge _d values together.
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      cin_q        <= cin_d;
      carry_q      <= carry_d;
      res_lo_q     <= res_lo_d;
      out_result_q <= out_result_d;
      out_czn_q    <= out_czn_d;
      out_err_q    <= out_err_d;
    end
  end
endmodule

// File: tb/tb_multibyte_alu_seq.sv
// Self-checking bench for multibyte_alu_seq: directed vector table, reset corners, random traffic
// against a 16-bit arithmetic model. Honours SEQ_CARRY_IN_EN the same way the design does.
`ifndef ADD_FN
`define ADD_FN 2'b00
`endif
`ifndef AND_FN
`define AND_FN 2'b01
`endif
`ifndef OR_FN
`define OR_FN 2'b10
`endif

module tb_multibyte_alu_seq;
  logic        clk, rst_n, in_valid, in_ready, cin_drv;
  logic [15:0] in_a, in_b, out_result;
  logic [1:0]  in_op, alu_opcode;
  logic [7:0]  alu_in1, alu_in2, alu_out;
  logic        alu_c_in, out_valid, out_ready, out_err, busy, alu_c;
  logic [2:0]  alu_czn, out_czn;
  logic [8:0]  alu_sum;
  int          total = 0;
  int          bad   = 0;

  multibyte_alu_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
`ifdef SEQ_CARRY_IN_EN
    .in_cin(cin_drv),
`endif
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_c_in(alu_c_in), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_czn(alu_czn), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_czn(out_czn), .out_err(out_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 8-bit ALU; its N flag is deliberately inverted so any use of it by the DUT is exposed.
  always_comb begin
    alu_sum = {1'b0, alu_in1} + {1'b0, alu_in2} + {8'd0, alu_c_in};
    alu_c   = 1'b0;
    case (alu_opcode)
      `ADD_FN: begin alu_out = alu_sum[7:0]; alu_c = alu_sum[8]; end
      `AND_FN: alu_out = alu_in1 & alu_in2;
      `OR_FN:  alu_out = alu_in1 | alu_in2;
      default: alu_out = 8'h00;
    endcase
    alu_czn = {~alu_out[7], (alu_out == 8'h00), alu_c};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic cin_eff(input logic cin);
`ifdef SEQ_CARRY_IN_EN
    return cin;
`else
    return 1'b0;
`endif
  endfunction

  // Whole-word reference: result, {N,Z,C} and error for one request.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                                input logic cin, output logic [15:0] r, output logic [2:0] czn,
                                output logic err);
    logic [16:0] s;
    logic        c;
    c   = 1'b0;
    err = 1'b0;
    case (op)
      `ADD_FN: begin s = {1'b0, a} + {1'b0, b} + {16'd0, cin_eff(cin)}; r = s[15:0]; c = s[16]; end
      `AND_FN: r = a & b;
      `OR_FN:  r = a | b;
      default: begin r = 16'h0000; err = 1'b1; end
    endcase
    czn = err ? 3'b000 : {r[15], (r == 16'h0000), c};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input logic cin, input int hold, input logic [15:0] er,
                        input logic [2:0] ec, input logic ee, input string tag);
    logic [8:0] lo;
    lo = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin_eff(cin)};
    check({tag, " in_ready idle"}, in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; cin_drv = cin;
    @(negedge clk);
    // Operands change and in_valid stays high: both must be ignored while busy.
    in_a = 16'($urandom); in_b = 16'($urandom); in_op = 2'($urandom); cin_drv = 1'($urandom);
    if (!ee) begin
      check({tag, " lo valid"}, out_valid, 0);
      check({tag, " lo in_ready"}, in_ready, 0);
      check({tag, " lo busy"}, busy, 1);
      check({tag, " lo in1"}, alu_in1, a[7:0]);
      check({tag, " lo in2"}, alu_in2, b[7:0]);
      check({tag, " lo opcode"}, alu_opcode, op);
      check({tag, " lo c_in"}, alu_c_in, (op == `ADD_FN) ? cin_eff(cin) : 1'b0);
      @(negedge clk);
      check({tag, " hi valid"}, out_valid, 0);
      check({tag, " hi in1"}, alu_in1, a[15:8]);
      check({tag, " hi in2"}, alu_in2, b[15:8]);
      check({tag, " hi opcode"}, alu_opcode, op);
      check({tag, " hi c_in"}, alu_c_in, (op == `ADD_FN) ? lo[8] : 1'b0);
      @(negedge clk);
    end
    for (int i = 0; i <= hold; i++) begin
      check({tag, " done valid"}, out_valid, 1);
      check({tag, " result"}, out_result, er);
      check({tag, " czn"}, out_czn, ec);
      check({tag, " err"}, out_err, ee);
      check({tag, " done in_ready"}, in_ready, 0);
      check({tag, " done busy"}, busy, 1);
      check({tag, " done alu idle"}, {alu_in1, alu_in2, alu_c_in, alu_opcode}, 0);
      if (i == hold) begin in_valid = 1'b0; out_ready = 1'b1; end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check({tag, " post valid"}, out_valid, 0);
    check({tag, " post in_ready"}, in_ready, 1);
    check({tag, " post result kept"}, out_result, er);
    check({tag, " post err kept"}, out_err, ee);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    int          hold;
    logic [15:0] res;
    logic [2:0]  czn;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] ra, rb, er;
    logic [1:0]  rop;
    logic        rcin, ee;
    logic [2:0]  ec;

    // czn packed {N,Z,C}
    vecs[0] = '{16'h00FF, 16'h0001, `ADD_FN, 0, 16'h0100, 3'b000, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, `ADD_FN, 1, 16'h0000, 3'b011, 1'b0};
    vecs[2] = '{16'h8F0F, 16'hF0FF, `AND_FN, 0, 16'h800F, 3'b100, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, `OR_FN,  0, 16'h0000, 3'b010, 1'b0};
    vecs[4] = '{16'h1234, 16'h5678, 2'b11,   2, 16'h0000, 3'b000, 1'b1};
    vecs[5] = '{16'h7FFF, 16'h0001, `ADD_FN, 5, 16'h8000, 3'b100, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, `ADD_FN, 0, 16'h0000, 3'b011, 1'b0};
    vecs[7] = '{16'h1200, 16'h0034, `OR_FN,  1, 16'h1234, 3'b000, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; cin_drv = 1'b0; out_ready = 1'b0;
    #3;
    check("reset in_ready", in_ready, 1);
    check("reset valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset outs", {out_result, out_czn, out_err}, 0);
    check("reset alu", {alu_in1, alu_in2, alu_c_in, alu_opcode}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      do_txn(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, vecs[i].hold,
             vecs[i].res, vecs[i].czn, vecs[i].err, $sformatf("vec%0d", i));

`ifdef SEQ_CARRY_IN_EN
    do_txn(16'h0000, 16'h0000, `ADD_FN, 1'b1, 0, 16'h0001, 3'b000, 1'b0, "cin add");
    do_txn(16'h00FF, 16'h0000, `ADD_FN, 1'b1, 0, 16'h0100, 3'b000, 1'b0, "cin ripple");
    do_txn(16'h0000, 16'h0000, `AND_FN, 1'b1, 0, 16'h0000, 3'b010, 1'b0, "cin and");
`else
    do_txn(16'h00FF, 16'h0000, `ADD_FN, 1'b1, 0, 16'h00FF, 3'b000, 1'b0, "no cin");
`endif

    // Reset during LO (p=0), HI (p=1) and DONE (p=2): everything clears and the request is dropped.
    for (int p = 0; p < 3; p++) begin
      in_valid = 1'b1; in_a = 16'h00FF; in_b = 16'h0001; in_op = `ADD_FN; cin_drv = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (p) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check($sformatf("rst%0d in_ready", p), in_ready, 1);
      check($sformatf("rst%0d valid", p), out_valid, 0);
      check($sformatf("rst%0d busy", p), busy, 0);
      check($sformatf("rst%0d outs", p), {out_result, out_czn, out_err}, 0);
      check($sformatf("rst%0d alu", p), {alu_in1, alu_in2, alu_c_in, alu_opcode}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check($sformatf("rst%0d no valid", p), out_valid, 0);
        check($sformatf("rst%0d idle", p), in_ready, 1);
      end
    end

    for (int n = 0; n < 40; n++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rop  = 2'($urandom_range(0, 3));
      rcin = 1'($urandom);
      model(ra, rb, rop, rcin, er, ec, ee);
      do_txn(ra, rb, rop, rcin, $urandom_range(0, 2), er, ec, ee, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
